mysystem_nios2_oci_dct_packer: RTL and testbench

Packs the 2-bit direct-branch trace codes produced by the Nios II OCI instruction-trace logic into 30-bit DCT frames of up to 15 codes. It sits directly upstream of the OCI test-bench monitor: it drives the live `dct_buffer`/`dct_count` accumulation state that the monitor consumes. It also emits completed frames through a valid/ready port towards the trace FIFO. Trace input cannot stall, so the block drops codes and flags overflow when the downstream side does not keep up.

---
 rtl/mysystem_nios2_oci_dct_packer_pkg.sv | 27 ++
 rtl/mysystem_nios2_oci_dct_outreg.sv | 53 +++++
 rtl/mysystem_nios2_oci_dct_packer.sv | 181 ++++++++++++++++++
 tb/tb_mysystem_nios2_oci_dct_packer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mysystem_nios2_oci_dct_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mysystem_nios2_oci_dct_packer_pkg
//  Description : Shared definitions for the OCI direct-branch trace (DCT)
//                packer: trace code encodings, padded buffer/count widths
//                and the frame record handed to the output register.
//  Revision    : 1.0 - initial release
// ============================================================================
package mysystem_nios2_oci_dct_packer_pkg;

    // Direct-branch trace code encodings
    localparam logic [1:0] DCT_NONE = 2'b00;
    localparam logic [1:0] DCT_NT   = 2'b01;
    localparam logic [1:0] DCT_T    = 2'b10;
    localparam logic [1:0] DCT_RSV  = 2'b11;

    // Buffers are always presented at the width of a 15-code frame
    localparam int C_BUF_W = 30;
    localparam int C_CNT_W = 4;

    typedef struct packed {
        logic [C_BUF_W-1:0] buffer;
        logic [C_CNT_W-1:0] count;
    } dct_frame_t;

endpackage : mysystem_nios2_oci_dct_packer_pkg
`default_nettype wire

// File: rtl/mysystem_nios2_oci_dct_outreg.sv
`default_nettype none
// ============================================================================
//  Module      : mysystem_nios2_oci_dct_outreg
//  Description : Single-entry valid/ready holding register for completed
//                DCT frames. The upstream packer only asserts load_i when
//                the slot is free (empty, or draining this cycle).
//  Ports       : clk, reset_n      - clock, async active-low reset
//                load_i            - capture buffer_i/count_i this cycle
//                buffer_i, count_i - frame to capture
//                ready_i           - downstream accepts the held frame
//                valid_o           - frame held
//                buffer_o, count_o - held frame
//  Revision    : 1.0 - initial release
// ============================================================================
module mysystem_nios2_oci_dct_outreg
    import mysystem_nios2_oci_dct_packer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,
    input  logic [C_BUF_W-1:0] buffer_i,
    input  logic [C_CNT_W-1:0] count_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic [C_BUF_W-1:0] buffer_o,
    output logic [C_CNT_W-1:0] count_o
);

    logic               valid_q;
    logic [C_BUF_W-1:0] buffer_q;
    logic [C_CNT_W-1:0] count_q;

    // Data only changes on load, so it stays stable while valid & !ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            buffer_q <= '0;
            count_q  <= '0;
        end else if (load_i) begin
            valid_q  <= 1'b1;
            buffer_q <= buffer_i;
            count_q  <= count_i;
        end else if (ready_i) begin
            valid_q  <= 1'b0;
        end
    end

    assign valid_o  = valid_q;
    assign buffer_o = buffer_q;
    assign count_o  = count_q;

endmodule : mysystem_nios2_oci_dct_outreg
`default_nettype wire

// File: rtl/mysystem_nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
//  Module      : mysystem_nios2_oci_dct_packer
//  Description : Packs 2-bit direct-branch trace codes into frames of up to
//                DCT_DEPTH codes. Owns the live accumulator, the frame close
//                logic and overflow tracking; completed frames leave through
//                a single-entry valid/ready output register. Trace input
//                cannot stall, so codes arriving while the accumulator is
//                stuck full behind an occupied output slot are dropped.
//  Ports       : clk, reset_n                 - clock, async active-low reset
//                trc_on, dct_code_valid,
//                dct_code                     - trace code input
//                flush                        - close a partial frame
//                frame_ready                  - downstream accept
//                ovf_clr                      - clear overflow status
//                dct_buffer, dct_count        - live accumulator state
//                frame_valid, frame_buffer,
//                frame_count                  - completed frame output
//                overflow                     - sticky drop flag
//                ovf_count                    - saturating drop counter
//  Config      : MYSYSTEM_OCI_DCT_OVF_CNT_EN adds the ovf_count port.
//  Revision    : 1.0 - initial release
// ============================================================================
module mysystem_nios2_oci_dct_packer
    import mysystem_nios2_oci_dct_packer_pkg::*;
#(
    parameter int DCT_DEPTH = 15
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               trc_on,
    input  logic               dct_code_valid,
    input  logic [1:0]         dct_code,
    input  logic               flush,
    input  logic               frame_ready,
    input  logic               ovf_clr,
    output logic [C_BUF_W-1:0] dct_buffer,
    output logic [C_CNT_W-1:0] dct_count,
    output logic               frame_valid,
    output logic [C_BUF_W-1:0] frame_buffer,
    output logic [C_CNT_W-1:0] frame_count,
`ifdef MYSYSTEM_OCI_DCT_OVF_CNT_EN
    output logic [7:0]         ovf_count,
`endif
    output logic               overflow
);

    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(DCT_DEPTH);
    localparam logic [C_CNT_W-1:0] C_DEPTH_M = C_CNT_W'(DCT_DEPTH - 1);

    logic [C_BUF_W-1:0] buf_q,  buf_d;
    logic [C_CNT_W-1:0] cnt_q,  cnt_d;
    logic               pend_q, pend_d;     // flush waiting for a free slot
    logic               trc_q;              // trc_on delayed, for fall detect
    logic               ovf_q,  ovf_d;

    logic               w_slot_free;
    logic               w_stuck;
    logic               w_code_in;
    logic               w_drop;
    logic               w_flush_req;
    logic               w_full_close;
    logic [C_BUF_W-1:0] w_acc_buf;
    logic [C_CNT_W-1:0] w_acc_cnt;
    logic               w_push;
    dct_frame_t         w_push_frame;

    assign w_slot_free = !frame_valid || frame_ready;
    assign w_stuck     = (cnt_q == C_DEPTH);
    assign w_code_in   = trc_on && dct_code_valid;
    assign w_drop      = w_code_in && w_stuck && !w_slot_free;
    // Flush and trc_on fall share one request path; a request left pending
    // is re-evaluated every cycle until the output slot frees.
    assign w_flush_req = (flush || (trc_q && !trc_on) || pend_q) && (cnt_q != '0);

    // Accumulator contents including any code accepted this cycle. The
    // register is cleared after every frame so bits above 2*DCT_DEPTH
    // stay zero without an explicit mask.
    assign w_acc_buf    = w_code_in ? {buf_q[C_BUF_W-3:0], dct_code} : buf_q;
    assign w_acc_cnt    = cnt_q + (w_code_in ? C_CNT_W'(1) : C_CNT_W'(0));
    assign w_full_close = w_code_in && (cnt_q == C_DEPTH_M);

    always_comb begin
        buf_d        = buf_q;
        cnt_d        = cnt_q;
        pend_d       = pend_q;
        w_push       = 1'b0;
        w_push_frame = '{buffer: buf_q, count: cnt_q};

        if (w_stuck) begin
            // Held full frame drains as soon as the slot frees; a code
            // arriving in that same cycle starts the next frame.
            if (w_slot_free) begin
                w_push = 1'b1;
                pend_d = 1'b0;
                buf_d  = w_code_in ? {{(C_BUF_W-2){1'b0}}, dct_code} : '0;
                cnt_d  = w_code_in ? C_CNT_W'(1) : '0;
            end
        end else if (w_full_close || w_flush_req) begin
            if (w_slot_free) begin
                w_push       = 1'b1;
                w_push_frame = '{buffer: w_acc_buf, count: w_acc_cnt};
                buf_d        = '0;
                cnt_d        = '0;
                pend_d       = 1'b0;
            end else begin
                // Full close parks at count DCT_DEPTH; flush stays pending.
                buf_d  = w_acc_buf;
                cnt_d  = w_acc_cnt;
                pend_d = w_flush_req;
            end
        end else begin
            buf_d = w_acc_buf;
            cnt_d = w_acc_cnt;
        end
    end

    // A drop in the same cycle as a clear leaves the flag set.
    assign ovf_d = w_drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q  <= '0;
            cnt_q  <= '0;
            pend_q <= 1'b0;
            trc_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            trc_q  <= trc_on;
            ovf_q  <= ovf_d;
        end
    end

`ifdef MYSYSTEM_OCI_DCT_OVF_CNT_EN
    logic [7:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (w_drop) begin
            if (ovf_clr) begin
                ovf_cnt_d = 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
                ovf_cnt_d = ovf_cnt_q + 8'd1;
            end
        end else if (ovf_clr) begin
            ovf_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_q <= 8'd0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_count = ovf_cnt_q;
`endif

    mysystem_nios2_oci_dct_outreg u_outreg (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (w_push),
        .buffer_i (w_push_frame.buffer),
        .count_i  (w_push_frame.count),
        .ready_i  (frame_ready),
        .valid_o  (frame_valid),
        .buffer_o (frame_buffer),
        .count_o  (frame_count)
    );

    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = ovf_q;

endmodule : mysystem_nios2_oci_dct_packer
`default_nettype wire

// File: tb/tb_mysystem_nios2_oci_dct_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mysystem_nios2_oci_dct_packer
//  Description : Self-checking bench for the DCT packer. Expected frames are
//                queued as stimulus is driven and checked when transferred.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mysystem_nios2_oci_dct_packer;
    import mysystem_nios2_oci_dct_packer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        trc_on, dct_code_valid, flush, frame_ready, ovf_clr;
    logic [1:0]  dct_code;
    logic [29:0] dct_buffer, frame_buffer;
    logic [3:0]  dct_count, frame_count;
    logic        frame_valid, overflow;
`ifdef MYSYSTEM_OCI_DCT_OVF_CNT_EN
    logic [7:0]  ovf_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dct_frame_t  sb_q[$];
    logic [29:0] m_buf = '0;
    logic [3:0]  m_cnt = '0;

    always #5 clk = ~clk;

    mysystem_nios2_oci_dct_packer #(.DCT_DEPTH(15)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .trc_on         (trc_on),
        .dct_code_valid (dct_code_valid),
        .dct_code       (dct_code),
        .flush          (flush),
        .frame_ready    (frame_ready),
        .ovf_clr        (ovf_clr),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .frame_valid    (frame_valid),
        .frame_buffer   (frame_buffer),
        .frame_count    (frame_count),
`ifdef MYSYSTEM_OCI_DCT_OVF_CNT_EN
        .ovf_count      (ovf_count),
`endif
        .overflow       (overflow)
    );

    // Scoreboard: a transfer happens on the next edge when valid & ready.
    always @(negedge clk) begin
        if (reset_n && frame_valid && frame_ready) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected: got buffer=%h count=%0d, required no frame",
                         frame_buffer, frame_count);
            end else begin
                dct_frame_t exp_f;
                exp_f = sb_q.pop_front();
                if (frame_buffer !== exp_f.buffer || frame_count !== exp_f.count) begin
                    n_fail++;
                    $display("FAIL frame_data: got buffer=%h count=%0d, required buffer=%h count=%0d",
                             frame_buffer, frame_count, exp_f.buffer, exp_f.count);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic v, input logic [1:0] c);
        dct_code_valid = v;
        dct_code       = c;
        tick();
        dct_code_valid = 1'b0;
    endtask

    task automatic model_add(input logic [1:0] c);
        m_buf = {m_buf[27:0], c};
        m_cnt = m_cnt + 4'd1;
    endtask

    task automatic model_push();
        dct_frame_t f;
        f.buffer = m_buf;
        f.count  = m_cnt;
        sb_q.push_back(f);
        m_buf = '0;
        m_cnt = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; trc_on = 1'b1; dct_code_valid = 1'b0; dct_code = 2'b00;
        flush = 1'b0; frame_ready = 1'b1; ovf_clr = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        n_tests++;
        if ({dct_buffer, dct_count, frame_valid, frame_buffer, frame_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got buf=%h cnt=%0d fv=%b fb=%h fc=%0d ovf=%b, required all 0",
                     dct_buffer, dct_count, frame_valid, frame_buffer, frame_count, overflow);
        end
    endtask

    task automatic test_fill();
        frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            model_add(DCT_T);
            if (i == 14) model_push();
            send(1'b1, DCT_T);
        end
        n_tests++;
        if (frame_valid !== 1'b1 || dct_count !== 4'd0) begin
            n_fail++;
            $display("FAIL fill_close: got fv=%b cnt=%0d, required fv=1 cnt=0", frame_valid, dct_count);
        end
        n_tests++;
        if (sb_q.size() != 1 || sb_q[0].buffer !== 30'h2AAAAAAA) begin
            n_fail++;
            $display("FAIL fill_model: got queue=%0d, required 1 frame of 2AAAAAAA", sb_q.size());
        end
        tick(); tick();
        n_tests++;
        if (sb_q.size() != 0 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drain: got pending=%0d fv=%b, required 0 0", sb_q.size(), frame_valid);
        end
    endtask

    task automatic test_flush();
        logic [1:0] codes [3];
        codes[0] = DCT_NT; codes[1] = DCT_T; codes[2] = DCT_RSV;
        for (int i = 0; i < 3; i++) begin
            model_add(codes[i]);
            send(1'b1, codes[i]);
        end
        n_tests++;
        if (dct_buffer !== 30'h1B || dct_count !== 4'd3) begin
            n_fail++;
            $display("FAIL flush_acc: got buf=%h cnt=%0d, required 1b 3", dct_buffer, dct_count);
        end
        model_push();
        flush = 1'b1; tick(); flush = 1'b0;
        n_tests++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd3 || dct_count !== 4'd0) begin
            n_fail++;
            $display("FAIL flush_close: got fv=%b fc=%0d cnt=%0d, required 1 3 0",
                     frame_valid, frame_count, dct_count);
        end
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        tick();
        n_tests++;
        if (frame_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL flush_empty: got fv=%b pending=%0d, required 0 0", frame_valid, sb_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [1:0] c;
        frame_ready = 1'b0;
        for (int i = 1; i <= 31; i++) begin
            c = 2'(i);
            if (i <= 30) begin
                model_add(c);
                if (i == 15 || i == 30) model_push();
            end
            send(1'b1, c);
        end
        n_tests++;
        if (frame_valid !== 1'b1 || dct_count !== 4'd15 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_stuck: got fv=%b cnt=%0d ovf=%b, required 1 15 1",
                     frame_valid, dct_count, overflow);
        end
        frame_ready = 1'b1;
        tick();
        n_tests++;
        if (frame_valid !== 1'b1 || dct_count !== 4'd0) begin
            n_fail++;
            $display("FAIL ovf_b2b: got fv=%b cnt=%0d, required 1 0", frame_valid, dct_count);
        end
        tick();
        n_tests++;
        if (frame_valid !== 1'b0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL ovf_drain: got fv=%b pending=%0d, required 0 0", frame_valid, sb_q.size());
        end
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b, required 0", overflow);
        end
    endtask

    task automatic test_simultaneous();
        logic [1:0] c;
        frame_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            c = 2'($urandom_range(0, 3));
            model_add(c);
            if (i == 14 || i == 29) model_push();
            send(1'b1, c);
        end
        // Drain cycle with a new code: joins the emptied accumulator.
        frame_ready = 1'b1;
        model_add(DCT_NT);
        send(1'b1, DCT_NT);
        frame_ready = 1'b0;
        n_tests++;
        if (dct_count !== 4'd1 || overflow !== 1'b0 || frame_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_drain: got cnt=%0d ovf=%b fv=%b, required 1 0 1",
                     dct_count, overflow, frame_valid);
        end
        for (int i = 0; i < 14; i++) begin
            c = 2'($urandom_range(0, 3));
            model_add(c);
            if (i == 13) model_push();
            send(1'b1, c);
        end
        n_tests++;
        if (dct_count !== 4'd15) begin
            n_fail++;
            $display("FAIL simul_stuck: got cnt=%0d, required 15", dct_count);
        end
        ovf_clr = 1'b1;
        send(1'b1, DCT_T);
        ovf_clr = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL simul_clr_set: got ovf=%b, required 1", overflow);
        end
        frame_ready = 1'b1;
        tick(); tick(); tick();
        n_tests++;
        if (sb_q.size() != 0 || dct_count !== 4'd0 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_final: got pending=%0d cnt=%0d fv=%b, required 0 0 0",
                     sb_q.size(), dct_count, frame_valid);
        end
    endtask

    task automatic test_trc_fall();
        logic [1:0] c;
        for (int i = 0; i < 4; i++) begin
            c = 2'(3 - i);
            model_add(c);
            send(1'b1, c);
        end
        model_push();
        trc_on = 1'b0;
        send(1'b1, DCT_T);
        n_tests++;
        if (frame_valid !== 1'b1 || frame_count !== 4'd4 || dct_count !== 4'd0) begin
            n_fail++;
            $display("FAIL trc_fall_close: got fv=%b fc=%0d cnt=%0d, required 1 4 0",
                     frame_valid, frame_count, dct_count);
        end
        for (int i = 0; i < 3; i++) send(1'b1, DCT_NT);
        trc_on = 1'b1;
        tick();
        n_tests++;
        if (dct_count !== 4'd0 || sb_q.size() != 0 || frame_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL trc_off_ignore: got cnt=%0d pending=%0d fv=%b, required 0 0 0",
                     dct_count, sb_q.size(), frame_valid);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 7; i++) send(1'b1, DCT_T);
        n_tests++;
        if (dct_count !== 4'd7 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: got cnt=%0d ovf=%b, required 7 1", dct_count, overflow);
        end
        #2 reset_n = 1'b0;
        #1;
        n_tests++;
        if ({dct_buffer, dct_count, frame_valid, frame_buffer, frame_count, overflow} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got buf=%h cnt=%0d fv=%b fb=%h fc=%0d ovf=%b, required all 0",
                     dct_buffer, dct_count, frame_valid, frame_buffer, frame_count, overflow);
        end
`ifdef MYSYSTEM_OCI_DCT_OVF_CNT_EN
        n_tests++;
        if (ovf_count !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_ovf_count: got %0d, required 0", ovf_count);
        end
`endif
        tick(); tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (frame_valid !== 1'b0 || dct_count !== 4'd0 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rst_release: got fv=%b cnt=%0d pending=%0d, required 0 0 0",
                     frame_valid, dct_count, sb_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_flush();
        test_overflow();
        test_simultaneous();
        test_trc_fall();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_mysystem_nios2_oci_dct_packer
`default_nettype wire
